// File: rtl/graphics_pkg.sv
// Shared frame-buffer geometry, pixel format and memory-port widths.
package graphics_pkg;

  localparam int WIDTH             = 160;
  localparam int HEIGHT            = 120;
  localparam int COORD_WIDTH       = 9;
  localparam int COLOR_DATA_WIDTH  = 8;
  localparam int MM_MEM_DATA_WIDTH = 16;
  localparam int MM_MEM_ADDR_WIDTH = 24;

  typedef logic [COORD_WIDTH-1:0] coordinate_t;

  typedef struct packed {
    coordinate_t                 x;
    coordinate_t                 y;
    logic [COLOR_DATA_WIDTH-1:0] color;
  } pixel_t;

endpackage

// File: rtl/graphics_pixel_fifo.sv
// Small show-ahead FIFO; head element is always visible on dout.
module graphics_pixel_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  T                           din,
  output T                           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T                r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array; no reset needed, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/graphics_pixel_writer.sv
// Streams pixels into an Avalon-MM frame buffer, one write per cycle when
// the slave does not stall.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// S_EMPTY   | output register free, mm_write low
// S_WRITING | output register holds a write, mm_write high until accepted
module graphics_pixel_writer
  import graphics_pkg::*;
#(
  parameter logic [31:0] MM_START_ADDRESS = 32'd0,
  parameter int          FIFO_DEPTH       = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clken,
  input  logic                           st_valid,
  input  pixel_t                         st_data,
  output logic                           st_ready,
  output logic                           mm_write,
  output logic [MM_MEM_ADDR_WIDTH-1:0]   mm_address,
  output logic [MM_MEM_DATA_WIDTH/8-1:0] mm_byteenable,
  output logic [MM_MEM_DATA_WIDTH-1:0]   mm_writedata,
  input  logic                           mm_waitrequest,
  output logic                           idle,
  output logic [15:0]                    dropped_count
);

  localparam int BYTES = MM_MEM_DATA_WIDTH / 8;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_EMPTY, S_WRITING} state_t;

  state_t                         r_state;
  logic                           r_write;
  logic [MM_MEM_ADDR_WIDTH-1:0]   r_addr;
  logic [MM_MEM_DATA_WIDTH-1:0]   r_data;
  logic [15:0]                    r_dropped;

  pixel_t                         w_head;
  logic                           w_full;
  logic                           w_empty;
  logic [CW-1:0]                  w_count;
  logic                           w_accept;
  logic                           w_on_screen;
  logic                           w_push;
  logic                           w_load;
  logic [31:0]                    w_addr_full;

  // Ready depends only on registered occupancy, never on the slave stall.
  assign st_ready    = reset_n && clken && !w_full;
  assign w_accept    = st_valid && st_ready;
  assign w_on_screen = (32'(st_data.x) < 32'(WIDTH)) && (32'(st_data.y) < 32'(HEIGHT));
  assign w_push      = w_accept && w_on_screen;

  // Load when the output register is free or being freed this edge.
  assign w_load = clken && !w_empty && ((r_state == S_EMPTY) || !mm_waitrequest);

  assign w_addr_full = MM_START_ADDRESS +
                       (32'(w_head.y) * 32'(WIDTH) + 32'(w_head.x)) * 32'(BYTES);

  assign mm_write      = r_write;
  assign mm_address    = r_addr;
  assign mm_writedata  = r_data;
  assign mm_byteenable = '1;
  assign idle          = (w_count == '0) && (r_state == S_EMPTY);
  assign dropped_count = r_dropped;

  graphics_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (pixel_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_load),
    .din     (st_data),
    .dout    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  // Output-register FSM: issue, hold through stalls, reload back-to-back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EMPTY;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_load) begin
            r_state <= S_WRITING;
            r_write <= 1'b1;
            r_addr  <= w_addr_full[MM_MEM_ADDR_WIDTH-1:0];
            r_data  <= MM_MEM_DATA_WIDTH'(w_head.color);
          end
        end
        S_WRITING: begin
          if (!mm_waitrequest) begin
            if (w_load) begin
              r_addr <= w_addr_full[MM_MEM_ADDR_WIDTH-1:0];
              r_data <= MM_MEM_DATA_WIDTH'(w_head.color);
            end else begin
              r_state <= S_EMPTY;
              r_write <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of accepted pixels that fell outside the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dropped <= '0;
    end else if (w_accept && !w_on_screen && (r_dropped != 16'hFFFF)) begin
      r_dropped <= r_dropped + 16'd1;
    end
  end

endmodule

// File: doc/graphics_pixel_writer.md
GRAPHICS_PIXEL_WRITER -- requirements
Module: graphics_pixel_writer

Interface
REQ-001 SHALL have parameter MM_START_ADDRESS, default 0, byte address of the frame-buffer pixel (0,0).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two, range 2..16, input buffer entries.
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port clken, input, 1 bit, enables accepting pixels and issuing new writes.
REQ-006 SHALL have port st_valid, input, 1 bit, Avalon-ST sink valid.
REQ-007 SHALL have port st_data, input, pixel_t, pixel x, y and color.
REQ-008 SHALL have port st_ready, output, 1 bit, Avalon-ST sink ready (readyLatency 0).
REQ-009 SHALL have port mm_write, output, 1 bit, Avalon-MM master write request.
REQ-010 SHALL have port mm_address, output, MM_MEM_ADDR_WIDTH bits, byte address.
REQ-011 SHALL have port mm_byteenable, output, MM_MEM_DATA_WIDTH/8 bits, byte enables.
REQ-012 SHALL have port mm_writedata, output, MM_MEM_DATA_WIDTH bits, pixel color, zero-extended.
REQ-013 SHALL have port mm_waitrequest, input, 1 bit, slave stall.
REQ-014 SHALL have port idle, output, 1 bit, high when FIFO empty and no write pending.
REQ-015 SHALL have port dropped_count, output, 16 bits, number of discarded off-screen pixels.

Function
REQ-016 SHALL accept a pixel on a clk edge where st_valid && st_ready.
REQ-017 SHALL drive st_ready = clken && FIFO not full, from registered occupancy only (no combinational path from mm_waitrequest).
REQ-018 SHALL discard, rather than push, any accepted pixel with x >= WIDTH or y >= HEIGHT, incrementing dropped_count by 1.
REQ-019 SHALL saturate dropped_count at 16'hFFFF.
REQ-020 SHALL use a 1-entry output register (states EMPTY, WRITING) holding address and data.
REQ-021 In EMPTY with FIFO non-empty and clken high, SHALL pop the head, load the output register, and enter WRITING on the next edge.
REQ-022 In WRITING, SHALL hold mm_write high with mm_address, mm_writedata and mm_byteenable stable until an edge with mm_waitrequest low.
REQ-023 On write completion with FIFO non-empty and clken high, SHALL reload in the same edge and stay in WRITING (back-to-back, one write per cycle); otherwise SHALL go to EMPTY.
REQ-024 SHALL compute address = MM_START_ADDRESS + (y*WIDTH + x) * (MM_MEM_DATA_WIDTH/8), computed at 32-bit width and truncated to MM_MEM_ADDR_WIDTH.
REQ-025 SHALL drive mm_byteenable all ones.
REQ-026 SHALL keep write order identical to acceptance order.
REQ-027 Latency: a pixel accepted into an empty block at edge N SHALL have mm_write high during the cycle after edge N+1.
REQ-028 When clken is low, SHALL not accept or pop, but an in-progress write SHALL complete per REQ-022.
REQ-029 On simultaneous push and pop with the FIFO full, SHALL not accept, because st_ready was already low.
REQ-030 SHALL drive idle high iff the FIFO is empty and the state is EMPTY.

Reset
REQ-031 On reset_n low, SHALL asynchronously clear FIFO pointers and count, state to EMPTY, dropped_count to 0, mm_write to 0, mm_address and mm_writedata to 0, and st_ready to 0.
REQ-032 Reset asserted mid-write SHALL abandon the write and lose buffered pixels; idle SHALL be 1 after release.

Structure
REQ-033 pixel_t, coordinate_t, WIDTH, HEIGHT, COLOR_DATA_WIDTH and MM_MEM_* widths SHALL come from the existing vga_pkg/graphics_pkg; no new package types.
REQ-034 The FIFO SHALL be a sub-module graphics_pixel_fifo (parameters DEPTH and the element type; ports push, pop, full, empty, count).

Verification
REQ-035 Single pixel (x=3,y=2,color=5), no stall -> one write, address (2*WIDTH+3)*BYTES, data 5, mm_write on the 2nd cycle after acceptance, then idle=1.
REQ-036 Row x=0..9, y=1, color=x+WIDTH, mm_waitrequest always low -> 10 writes on consecutive cycles, in order, at consecutive addresses.
REQ-037 Random mm_waitrequest at 30% over 50 pixels -> address and data stable during stalls, no loss or duplication, st_ready low whenever FIFO_DEPTH entries are buffered.
REQ-038 Pixels (WIDTH,0), (0,HEIGHT) and (1,1) -> only the (1,1) write is issued, dropped_count=2.
REQ-039 clken low for 5 cycles mid-stream with a stalled write -> the stalled write completes, no new accept or pop, and the stream resumes intact.
REQ-040 reset_n pulsed low during WRITING with 3 pixels buffered -> mm_write=0 immediately, idle=1 and dropped_count=0 after release, and the next pixel is written correctly.
